axi4_rd_arbiter: RTL and testbench

AXI4_RD_ARBITER -- requirements
Module: axi4_rd_arbiter

---
 rtl/axi4_rd_arbiter.sv | 177 +++++++++++++++++
 tb/tb_axi4_rd_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rd_arbiter.sv
// Round-robin arbiter that lets N AXI4 read masters share one slave, one read in flight at a time.
// Latency: one IDLE cycle to register the winner, then AR and R are forwarded combinationally.
// Backpressure: s_arready and the granted master's rready pass straight through; a stalled beat holds its state.
module axi4_rd_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MASTERS-1:0]      m_arvalid,
    output logic [N_MASTERS-1:0]      m_arready,
    input  logic [N_MASTERS*ADDR_W-1:0] m_araddr,
    input  logic [N_MASTERS*ID_W-1:0] m_arid,
    input  logic [N_MASTERS*8-1:0]    m_arlen,
    output logic [N_MASTERS-1:0]      m_rvalid,
    input  logic [N_MASTERS-1:0]      m_rready,
    output logic [DATA_W-1:0]         m_rdata,
    output logic [ID_W-1:0]           m_rid,
    output logic [1:0]                m_rresp,
    output logic                      m_rlast,
    output logic                      s_arvalid,
    input  logic                      s_arready,
    output logic [ADDR_W-1:0]         s_araddr,
    output logic [ID_W-1:0]           s_arid,
    output logic [7:0]                s_arlen,
    input  logic                      s_rvalid,
    output logic                      s_rready,
    input  logic [DATA_W-1:0]         s_rdata,
    input  logic [ID_W-1:0]           s_rid,
    input  logic [1:0]                s_rresp,
    input  logic                      s_rlast,
    output logic [$clog2(N_MASTERS)-1:0] grant,
    output logic                      busy,
    output logic                      err
);

    localparam int GW = $clog2(N_MASTERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   rr_ptr;
    logic [7:0]      beat_cnt;
    logic            win_vld;
    logic [GW-1:0]   win_idx;
    logic            r_hs;

    // Round-robin search: scan downwards so the candidate closest to rr_ptr is the last (winning) assignment
    always_comb begin
        int            idx;
        logic [GW-1:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            idx  = (int'(rr_ptr) + k) % N_MASTERS;
            cand = GW'(idx);
            if (m_arvalid[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // R handshake on the granted master's port; only acted upon in DATA
    always_comb begin
        r_hs = s_rvalid && m_rready[grant];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a withdrawn AR request abandons the grant, rlast always closes the burst
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (!m_arvalid[grant]) begin
                    state_nxt = IDLE;
                end else if (s_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (r_hs && s_rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, beat counter, round-robin pointer and sticky length-error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant    <= win_idx;
                        beat_cnt <= m_arlen[int'(win_idx)*8 +: 8];
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt - 8'd1;
                        if (s_rlast != (beat_cnt == 8'd0)) begin
                            err <= 1'b1;
                        end
                        if (s_rlast) begin
                            rr_ptr <= (grant == GW'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: route AR in ADDR and R in DATA to/from the granted master only; everything else quiet
    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rid     = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arid    = '0;
        s_arlen   = '0;
        s_rready  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            ADDR: begin
                s_arvalid        = m_arvalid[grant];
                s_araddr         = m_araddr[int'(grant)*ADDR_W +: ADDR_W];
                s_arid           = m_arid[int'(grant)*ID_W +: ID_W];
                s_arlen          = m_arlen[int'(grant)*8 +: 8];
                m_arready[grant] = s_arready;
            end
            DATA: begin
                m_rvalid[grant]  = s_rvalid;
                s_rready         = m_rready[grant];
                m_rdata          = s_rdata;
                m_rid            = s_rid;
                m_rresp          = s_rresp;
                m_rlast          = s_rlast;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed bench for axi4_rd_arbiter: single read, backpressure, length error, withdraw, reset mid-burst, fairness.
// Drives inputs just after the rising edge, samples outputs a step later.
// Every check is an immediate assertion; the summary reports passed/total.
module tb_axi4_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   m_arvalid;
    logic [N-1:0]   m_arready;
    logic [N*AW-1:0] m_araddr;
    logic [N*IW-1:0] m_arid;
    logic [N*8-1:0] m_arlen;
    logic [N-1:0]   m_rvalid;
    logic [N-1:0]   m_rready;
    logic [DW-1:0]  m_rdata;
    logic [IW-1:0]  m_rid;
    logic [1:0]     m_rresp;
    logic           m_rlast;
    logic           s_arvalid;
    logic           s_arready;
    logic [AW-1:0]  s_araddr;
    logic [IW-1:0]  s_arid;
    logic [7:0]     s_arlen;
    logic           s_rvalid;
    logic           s_rready;
    logic [DW-1:0]  s_rdata;
    logic [IW-1:0]  s_rid;
    logic [1:0]     s_rresp;
    logic           s_rlast;
    logic [1:0]     grant;
    logic           busy;
    logic           err;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    axi4_rd_arbiter #(
        .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arid(m_arid), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arid(s_arid), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .grant(grant), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] got [5];
    logic [2:0] exp_order [5];

    initial begin
        rst       = 1'b1;
        m_arvalid = '0;
        m_araddr  = '0;
        m_arid    = '0;
        m_arlen   = '0;
        m_rready  = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rid     = '0;
        s_rresp   = '0;
        s_rlast   = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_err", err, 0);
        chk("rst_m_arready", m_arready, 0);
        chk("rst_m_rvalid", m_rvalid, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        tick();
        tick();
        rst = 1'b0;

        // Single read from master 2, arlen=3
        m_arvalid = 4'b0100;
        m_araddr[2*AW +: AW] = 32'h0000_1000;
        m_arid[2*IW +: IW]   = 4'h5;
        m_arlen[2*8 +: 8]    = 8'd3;
        #1;
        chk("idle_s_arvalid", s_arvalid, 0);
        chk("idle_m_arready", m_arready, 0);
        tick();
        chk("t1_grant", grant, 2);
        chk("t1_busy", busy, 1);
        chk("t1_s_arvalid", s_arvalid, 1);
        chk("t1_s_araddr", s_araddr, 32'h1000);
        chk("t1_s_arid", s_arid, 4'h5);
        chk("t1_s_arlen", s_arlen, 8'd3);
        chk("t1_m_arready_wait", m_arready, 0);
        s_arready = 1'b1;
        #1;
        chk("t1_m_arready", m_arready, 4'b0100);
        tick();
        m_arvalid = '0;
        s_arready = 1'b0;
        m_rready  = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            s_rvalid = 1'b1;
            s_rdata  = 64'hA0 + 64'(b);
            s_rid    = 4'h5;
            s_rlast  = (b == 3);
            #1;
            chk("t1_m_rvalid", m_rvalid, 4'b0100);
            chk("t1_m_rdata", m_rdata, 64'hA0 + 64'(b));
            chk("t1_s_rready", s_rready, 1);
            chk("t1_data_s_arvalid", s_arvalid, 0);
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        chk("t1_busy_end", busy, 0);
        chk("t1_err", err, 0);
        chk("t1_m_rvalid_end", m_rvalid, 0);

        // Backpressure on master 1, arlen=2
        m_arvalid = 4'b0010;
        m_araddr[1*AW +: AW] = 32'h0000_2000;
        m_arlen[1*8 +: 8]    = 8'd2;
        s_arready = 1'b1;
        tick();
        chk("t2_grant", grant, 1);
        chk("t2_m_arready", m_arready, 4'b0010);
        chk("t2_s_araddr", s_araddr, 32'h2000);
        tick();
        m_arvalid = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = 64'hB0;
        s_rlast   = 1'b0;
        m_rready  = 4'b1111;
        #1;
        chk("t2_s_rready_b0", s_rready, 1);
        tick();
        s_rdata   = 64'hB1;
        m_rready  = 4'b1101;
        m_arvalid = 4'b1101;
        repeat (5) begin
            #1;
            chk("t2_bp_s_rready", s_rready, 0);
            chk("t2_bp_m_rvalid", m_rvalid, 4'b0010);
            chk("t2_bp_m_rdata", m_rdata, 64'hB1);
            chk("t2_bp_grant", grant, 1);
            chk("t2_bp_m_arready", m_arready, 0);
            tick();
        end
        m_rready  = 4'b1111;
        m_arvalid = '0;
        #1;
        chk("t2_s_rready_b1", s_rready, 1);
        tick();
        s_rdata = 64'hB2;
        s_rlast = 1'b1;
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        chk("t2_busy_end", busy, 0);
        chk("t2_err", err, 0);

        // Length error: master 0, arlen=1, rlast on first beat
        m_arvalid = 4'b0001;
        m_arlen[0 +: 8] = 8'd1;
        s_arready = 1'b1;
        tick();
        chk("t3_grant", grant, 0);
        tick();
        m_arvalid = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rlast   = 1'b1;
        #1;
        chk("t3_err_before", err, 0);
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        chk("t3_err", err, 1);
        chk("t3_busy", busy, 0);
        tick();
        tick();
        chk("t3_err_sticky", err, 1);

        // Withdraw: master 3 drops arvalid while s_arready is low
        m_arvalid = 4'b1000;
        tick();
        chk("t4_grant", grant, 3);
        chk("t4_s_arvalid", s_arvalid, 1);
        chk("t4_m_arready", m_arready, 0);
        m_arvalid = '0;
        #1;
        chk("t4_s_arvalid_drop", s_arvalid, 0);
        tick();
        chk("t4_busy", busy, 0);
        // rr_ptr still 1: masters 0 and 2 competing -> 2 wins
        m_arvalid = 4'b0101;
        tick();
        chk("t4_rr_unchanged", grant, 2);
        m_arvalid = '0;
        tick();
        chk("t4_busy2", busy, 0);

        // Reset in the middle of an arlen=7 burst from master 1
        m_arvalid = 4'b0010;
        m_arlen[1*8 +: 8] = 8'd7;
        s_arready = 1'b1;
        tick();
        tick();
        m_arvalid = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rlast   = 1'b0;
        m_rready  = 4'b1111;
        s_rdata   = 64'hC0;
        tick();
        s_rdata = 64'hC1;
        tick();
        s_rdata = 64'hC2;
        #1;
        chk("t6_m_rvalid_pre", m_rvalid, 4'b0010);
        chk("t6_err_pre", err, 1);
        rst = 1'b1;
        #1;
        chk("t6_m_rvalid", m_rvalid, 0);
        chk("t6_s_rready", s_rready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant, 0);
        chk("t6_err", err, 0);
        chk("t6_m_rdata", m_rdata, 0);
        chk("t6_s_arvalid", s_arvalid, 0);

        // Fairness from reset: everyone requests single-beat reads continuously
        s_rvalid  = 1'b1;
        s_rlast   = 1'b1;
        s_arready = 1'b1;
        m_rready  = 4'b1111;
        m_arlen   = '0;
        m_arvalid = 4'b1111;
        tick();
        chk("t5_rst_s_arvalid", s_arvalid, 0);
        chk("t5_rst_m_arready", m_arready, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) got[i] = 3'b111;
        exp_order[0] = 3'd0;
        exp_order[1] = 3'd1;
        exp_order[2] = 3'd2;
        exp_order[3] = 3'd3;
        exp_order[4] = 3'd0;
        begin
            int n;
            n = 0;
            for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
                tick();
                if (s_arvalid) begin
                    got[n] = {1'b0, grant};
                    n++;
                end
            end
            chk("t5_count", 64'(n), 5);
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5_order%0d", i), got[i], exp_order[i]);
        end
        chk("t5_err", err, 0);

        m_arvalid = '0;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        s_arready = 1'b0;
        tick();
        tick();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
